uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DataWidth, default 8, meaning payload bits per frame (legal range 5-16).
REQ-002 The block SHALL have parameter ParityEn, default 0, meaning that 1 inserts one parity bit after the data bits.
REQ-003 The block SHALL have parameter ParityOdd, default 0, meaning that 1 selects odd parity and 0 selects even parity; it is ignored when ParityEn=0.
REQ-004 The block SHALL have parameter StopBits, default 1, meaning the number of stop bits per frame (legal values 1 or 2).
REQ-005 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous assertion, active-low.
REQ-007 tick_i  input  1  baud strobe, one clk_i cycle wide, once per bit period; the line advances one bit per tick.
REQ-008 valid_i  input  1  a payload word is offered on data_i.
REQ-009 data_i  input  DataWidth  payload word, transmitted LSB first.
REQ-010 ready_o  output  1  the holding register is empty and can accept a word.
REQ-011 txd_o  output  1  serial line, registered, idle-high.
REQ-012 busy_o  output  1  a frame is in progress or a word is pending.
REQ-013 done_o  output  1  one-cycle pulse when the final stop bit period completes.

Function
REQ-014 A word SHALL be accepted into a one-entry holding register on any clk_i edge where valid_i=1 and ready_o=1; data_i is ignored otherwise.
REQ-015 ready_o SHALL equal the inverse of the holding-register-full flag (registered, no combinational path from valid_i).
REQ-016 The state machine SHALL have the states Idle, StartBit, DataBits, ParityBit and StopBit, and SHALL change state only on edges where tick_i=1.
REQ-017 Idle with holding register full and tick_i=1: load the shift register from the holding register, clear full, txd_o<=0, go to StartBit; with holding register empty, remain in Idle with txd_o=1.
REQ-018 StartBit on tick: txd_o<=shift[0], shift right by one, bit count<=0, go to DataBits.
REQ-019 DataBits on tick: if bit count<DataWidth-1, txd_o<=shift[0], shift, and increment the count; otherwise, go to ParityBit with txd_o<=parity when ParityEn=1, else go to StopBit with txd_o<=1.
REQ-020 Parity SHALL be the XOR of all DataWidth bits of the loaded word, inverted when ParityOdd=1, and captured at load time.
REQ-021 ParityBit on tick: txd_o<=1, stop count<=0, go to StopBit.
REQ-022 StopBit on tick when stop count<StopBits-1: increment the stop count and hold txd_o=1.
REQ-023 StopBit on tick when stop count=StopBits-1: pulse done_o for that cycle; if the holding register is full, load it, txd_o<=0 and go to StartBit (back-to-back, no idle bit); else go to Idle.
REQ-024 Each bit SHALL occupy exactly one tick period on txd_o; frame length is 1+DataWidth+ParityEn+StopBits ticks.
REQ-025 If an accept and a load occur on the same edge, the load SHALL take the old holding contents; this cannot happen because ready_o=0 whenever the register is full. An accept on the final StopBit tick with the holding register empty SHALL go to Idle and start on the next tick.
REQ-026 busy_o SHALL be 1 when the state is not Idle or the holding register is full.
REQ-027 With tick_i held high continuously, the block SHALL advance one bit per clk_i cycle with no lost or repeated bits.
REQ-028 The bit counter SHALL be max(1,$clog2(DataWidth)) bits wide; the count SHALL never exceed DataWidth-1.

Reset
REQ-029 While rst_ni=0: state=Idle, txd_o=1, ready_o=1, busy_o=0, done_o=0, holding register empty, and shift, parity and counters zero.
REQ-030 Reset asserted mid-frame SHALL force txd_o=1 immediately, without waiting for clk_i, and discard both the in-flight frame and any pending word.
REQ-031 After rst_ni deasserts, the first frame SHALL start only on a tick following a valid accept.

Verification
REQ-032 Defaults, accept 0xA5 then tick every 16 cycles -> txd_o per tick 0,1,0,1,0,0,1,0,1,1; done_o high once; busy_o low afterwards.
REQ-033 ParityEn=1, ParityOdd=0, data 0x07 -> parity bit 1; with ParityOdd=1 -> parity bit 0; frame is 11 ticks.
REQ-034 Accept 0x01 and 0xFF back-to-back (the second accept is made while the first frame is in DataBits) -> no idle bit between frames, ready_o low from the second accept until its load, done_o pulses twice.
REQ-035 StopBits=2, tick_i held high -> frame is exactly 11 cycles and txd_o is high for 2 cycles before the next start bit.
REQ-036 rst_ni low during bit 3 of the frame 0x00 -> txd_o=1 asynchronously, ready_o=1, no done_o, line idle until a new accept.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: word handshake between a producer and the UART transmitter.
// The producer offers a word with valid_i/data_i; the transmitter answers
// with ready_o while its holding register is empty.
interface uart_tx_if #(
    parameter int DataWidth = 8
);
    logic                 valid_i;
    logic [DataWidth-1:0] data_i;
    logic                 ready_o;

    // Producer side: drives the word, watches ready.
    modport master (
        output valid_i,
        output data_i,
        input  ready_o
    );

    // Transmitter side: samples the word, drives ready.
    modport slave (
        input  valid_i,
        input  data_i,
        output ready_o
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: tick-paced UART transmitter with a one-word holding register.
// Frame on txd_o: start bit (0), DataWidth data bits LSB first, optional
// parity bit, then StopBits stop bits (1). A word that is pending when the
// last stop bit ends starts the next frame immediately, with no idle bit.
module uart_tx #(
    parameter int DataWidth = 8,
    parameter int ParityEn  = 0,
    parameter int ParityOdd = 0,
    parameter int StopBits  = 1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     tick_i,
    uart_tx_if.slave bus,
    output logic     txd_o,
    output logic     busy_o,
    output logic     done_o
);
    localparam int CntWidth = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [CntWidth-1:0] LastBit = CntWidth'(DataWidth - 1);
    // Stop counter is one bit wide: it only ever has to reach StopBits-1 (0 or 1).
    localparam logic LastStop = (StopBits > 1);
    localparam logic OddSel   = (ParityOdd != 0);

    typedef enum logic [2:0] {
        Idle,
        StartBit,
        DataBits,
        ParityBit,
        StopBit
    } state_e;

    state_e                state;
    logic [DataWidth-1:0]  hold;
    logic [DataWidth-1:0]  shift;
    logic                  full;
    logic                  parity;
    logic                  stop_cnt;
    logic [CntWidth-1:0]   bit_cnt;
    logic                  accept;
    logic                  hold_parity;

    // ready is the registered inverse of the full flag, so valid never
    // reaches ready combinationally.
    assign accept      = bus.valid_i && !full;
    assign hold_parity = (^hold) ^ OddSel;
    assign bus.ready_o = !full;
    assign busy_o      = (state != Idle) || full;

    // Holding register, shifter and frame state machine with registered line outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the datapath registers are reset too, so shift, parity and the
            // counters start from zero and no stale word can leak into a frame.
            state    <= Idle;
            hold     <= '0;
            full     <= 1'b0;
            shift    <= '0;
            parity   <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            txd_o    <= 1'b1;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;

            // NOTE: accept needs full=0 and every load needs full=1, so the two
            // non-blocking writes to full below can never collide on one edge.
            if (accept) begin
                hold <= bus.data_i;
                full <= 1'b1;
            end

            if (tick_i) begin
                case (state)
                    Idle: begin
                        if (full) begin
                            shift  <= hold;
                            parity <= hold_parity;
                            full   <= 1'b0;
                            txd_o  <= 1'b0;
                            state  <= StartBit;
                        end else begin
                            txd_o <= 1'b1;
                        end
                    end
                    StartBit: begin
                        txd_o   <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                        state   <= DataBits;
                    end
                    DataBits: begin
                        if (bit_cnt < LastBit) begin
                            txd_o   <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + CntWidth'(1);
                        end else if (ParityEn != 0) begin
                            txd_o <= parity;
                            state <= ParityBit;
                        end else begin
                            txd_o    <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= StopBit;
                        end
                    end
                    ParityBit: begin
                        txd_o    <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= StopBit;
                    end
                    StopBit: begin
                        if (stop_cnt < LastStop) begin
                            stop_cnt <= 1'b1;
                            txd_o    <= 1'b1;
                        end else begin
                            done_o <= 1'b1;
                            if (full) begin
                                // Back-to-back: the pending word's start bit follows at once.
                                shift  <= hold;
                                parity <= hold_parity;
                                full   <= 1'b0;
                                txd_o  <= 1'b0;
                                state  <= StartBit;
                            end else begin
                                txd_o <= 1'b1;
                                state <= Idle;
                            end
                        end
                    end
                    default: begin
                        txd_o <= 1'b1;
                        state <= Idle;
                    end
                endcase
            end
        end
    end
endmodule
